// File: rtl/mprj_logic_pkg.sv
// Shared types and elaboration-time helpers for the staged logic-high bank.
package mprj_logic_pkg;

    // Ramp controller state.
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        UP   = 2'd1,
        ON   = 2'd2,
        DOWN = 2'd3
    } state_t;

    // Integer ceiling division; used for the group width.
    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Ceiling log2 (clog2(1) == 0).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (longint unsigned p = 1; p < longint'(v); p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Ceiling log2 clamped to at least one bit, for counter widths.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned c;
        c = clog2(v);
        return (c == 0) ? 1 : c;
    endfunction

endpackage

// File: rtl/mprj_stage_timer.sv
// Stage interval down-counter.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : force count to 0 (priority over load)
//   load      : load count with RELOAD
//   hold      : freeze count when not loading/clearing
//   expired_c : count == 0 (combinational view of the register)
module mprj_stage_timer #(
    parameter int unsigned TW     = 4,
    parameter int unsigned RELOAD = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    input  logic hold,
    output logic expired_c
);

    logic [TW-1:0] count_q;

    // Saturating down-count: never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= TW'(RELOAD);
        end else if (!hold && (count_q != '0)) begin
            count_q <= count_q - TW'(1);
        end
    end

    assign expired_c = (count_q == '0);

endmodule

// File: rtl/mprj_logic_high_seq.sv
// Staged logic-high enable bank for the user-project boundary.
// Groups of GW bits are raised one per STAGE_CYCLES toward the level request
// and lowered in reverse order; force_off_i drops everything on the next edge.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   enable_i           : level request (1 = all groups high)
//   force_off_i        : synchronous kill
//   HI                 : registered staged bank
//   ready_o, busy_o    : all groups high / ramp in progress
//   level_o            : number of groups currently high
module mprj_logic_high_seq
    import mprj_logic_pkg::*;
#(
    parameter int unsigned WIDTH        = 463,
    parameter int unsigned GROUPS       = 4,
    parameter int unsigned STAGE_CYCLES = 16
) (
    input  logic                                 wb_clk_i,
    input  logic                                 wb_rst_i,
    input  logic                                 enable_i,
    input  logic                                 force_off_i,
    output logic [WIDTH-1:0]                     HI,
    output logic                                 ready_o,
    output logic                                 busy_o,
    output logic [mprj_logic_pkg::clog2(GROUPS+1)-1:0] level_o
);

    localparam int unsigned GW = ceil_div(WIDTH, GROUPS);
    localparam int unsigned LW = clog2(GROUPS + 1);
    localparam int unsigned TW = clog2_min1(STAGE_CYCLES);

    state_t          state_q, state_d;
    logic [LW-1:0]   level_q, level_d;
    logic [LW-1:0]   target;
    logic [WIDTH-1:0] hi_d;
    logic            ready_d, busy_d;
    logic            t_clear, t_load, t_hold, t_expired;

    mprj_stage_timer #(
        .TW     (TW),
        .RELOAD (STAGE_CYCLES - 1)
    ) u_timer (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .clear     (t_clear),
        .load      (t_load),
        .hold      (t_hold),
        .expired_c (t_expired)
    );

    // Next level/state: a step happens on entry into a ramp direction
    // (from OFF/ON or a reversal) or when the stage timer has expired.
    always_comb begin
        level_d = level_q;
        state_d = state_q;
        t_clear = 1'b0;
        t_load  = 1'b0;
        t_hold  = !((state_q == UP) || (state_q == DOWN));
        target  = enable_i ? LW'(GROUPS) : '0;
        hi_d    = '0;

        if (force_off_i) begin
            level_d = '0;
        end else if (level_q < target) begin
            if ((state_q != UP) || t_expired) begin
                level_d = level_q + LW'(1);
                t_load  = 1'b1;
            end
        end else if (level_q > target) begin
            if ((state_q != DOWN) || t_expired) begin
                level_d = level_q - LW'(1);
                t_load  = 1'b1;
            end
        end

        // Classify against the new level so outputs agree with HI.
        if (force_off_i) begin
            state_d = OFF;
        end else if (level_d < target) begin
            state_d = UP;
        end else if (level_d > target) begin
            state_d = DOWN;
        end else if (target == '0) begin
            state_d = OFF;
        end else begin
            state_d = ON;
        end

        // Timer rests at zero whenever no ramp is pending.
        if ((state_d == OFF) || (state_d == ON)) begin
            t_clear = 1'b1;
        end

        // Bit i belongs to group i/GW and is high once that group is released.
        for (int i = 0; i < int'(WIDTH); i++) begin
            hi_d[i] = (level_d > LW'(i / int'(GW)));
        end

        ready_d = (state_d == ON);
        busy_d  = (state_d == UP) || (state_d == DOWN);
    end

    // State, level and all outputs are registered together.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= OFF;
            level_q <= '0;
            HI      <= '0;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            HI      <= hi_d;
            ready_o <= ready_d;
            busy_o  <= busy_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: tb/tb_mprj_logic_high_seq.sv
module tb_mprj_logic_high_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0, f_a = 1'b0;
    logic en_b = 1'b0, f_b = 1'b0;

    logic [9:0]   hi_a;
    logic [2:0]   level_a;
    logic         ready_a, busy_a;
    logic [462:0] hi_b;
    logic [0:0]   level_b;
    logic         ready_b, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mprj_logic_high_seq #(.WIDTH(10), .GROUPS(4), .STAGE_CYCLES(3)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(en_a), .force_off_i(f_a),
        .HI(hi_a), .ready_o(ready_a), .busy_o(busy_a), .level_o(level_a)
    );

    mprj_logic_high_seq #(.WIDTH(463), .GROUPS(1), .STAGE_CYCLES(1)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(en_b), .force_off_i(f_b),
        .HI(hi_b), .ready_o(ready_b), .busy_o(busy_b), .level_o(level_b)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: level moves one group per STAGE_CYCLES edges toward
    // the request; a change of direction (or a start) moves immediately.
    task automatic mstep(input logic r, input logic f, input logic en,
                         input int g, input int sc,
                         input int lvl_i, input int dir_i, input int cnt_i,
                         output int lvl_o, output int dir_o, output int cnt_o,
                         output int tgt_o);
        int d;
        lvl_o = lvl_i; dir_o = dir_i; cnt_o = cnt_i;
        if (r || f) begin
            lvl_o = 0; dir_o = 0; cnt_o = 0; tgt_o = 0;
        end else begin
            tgt_o = en ? g : 0;
            d = (tgt_o > lvl_i) ? 1 : ((tgt_o < lvl_i) ? -1 : 0);
            if (d == 0) begin
                dir_o = 0; cnt_o = 0;
            end else if (d != dir_i) begin
                lvl_o = lvl_i + d; dir_o = d; cnt_o = 0;
            end else begin
                cnt_o = cnt_i + 1;
                if (cnt_o == sc) begin
                    lvl_o = lvl_i + d; cnt_o = 0;
                end
            end
            if (lvl_o == tgt_o) dir_o = 0;
        end
    endtask

    function automatic logic [511:0] exp_hi(input int lvl, input int gw, input int w);
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < w; i++) if (i < lvl * gw) v[i] = 1'b1;
        return v;
    endfunction

    int ma_lvl = 0, ma_dir = 0, ma_cnt = 0, ma_tgt = 0;
    int mb_lvl = 0, mb_dir = 0, mb_cnt = 0, mb_tgt = 0;
    bit mvalid = 1'b0;

    always @(posedge clk) begin
        mstep(rst, f_a, en_a, 4, 3, ma_lvl, ma_dir, ma_cnt, ma_lvl, ma_dir, ma_cnt, ma_tgt);
        mstep(rst, f_b, en_b, 1, 1, mb_lvl, mb_dir, mb_cnt, mb_lvl, mb_dir, mb_cnt, mb_tgt);
        mvalid = 1'b1;
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("a_hi",    512'(hi_a),    exp_hi(ma_lvl, 3, 10));
            chk("a_level", 512'(level_a), 512'(ma_lvl));
            chk("a_ready", 512'(ready_a), 512'(ma_lvl == 4 && ma_tgt == 4));
            chk("a_busy",  512'(busy_a),  512'(ma_lvl != ma_tgt));
            chk("b_hi",    512'(hi_b),    exp_hi(mb_lvl, 463, 463));
            chk("b_level", 512'(level_b), 512'(mb_lvl));
            chk("b_ready", 512'(ready_b), 512'(mb_lvl == 1 && mb_tgt == 1));
            chk("b_busy",  512'(busy_b),  512'(mb_lvl != mb_tgt));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [462:0] ones;

    initial begin
        ones = '1;
        edges(2);
        chk("rst_hi",    512'(hi_a),    512'(0));
        chk("rst_ready", 512'(ready_a), 512'(0));
        chk("rst_busy",  512'(busy_a),  512'(0));
        chk("rst_level", 512'(level_a), 512'(0));
        chk("rst_hi_b",  512'(hi_b),    512'(0));
        rst = 1'b0;
        edges(1);

        // Ramp up
        en_a = 1'b1;
        edges(1);
        chk("up_e0",      512'(hi_a),   512'(10'h007));
        chk("up_e0_busy", 512'(busy_a), 512'(1));
        edges(3); chk("up_e3", 512'(hi_a), 512'(10'h03F));
        edges(3); chk("up_e6", 512'(hi_a), 512'(10'h1FF));
        edges(2); chk("up_e8_busy", 512'(busy_a), 512'(1));
        edges(1);
        chk("up_e9",       512'(hi_a),    512'(10'h3FF));
        chk("up_e9_ready", 512'(ready_a), 512'(1));
        chk("up_e9_busy",  512'(busy_a),  512'(0));
        edges(10);

        // Ramp down from ON
        en_a = 1'b0;
        edges(1);
        chk("dn_e20",       512'(hi_a),    512'(10'h1FF));
        chk("dn_e20_ready", 512'(ready_a), 512'(0));
        edges(3); chk("dn_e23", 512'(hi_a), 512'(10'h03F));
        edges(3); chk("dn_e26", 512'(hi_a), 512'(10'h007));
        edges(3); chk("dn_e29", 512'(hi_a), 512'(10'h000));
        edges(2);

        // Reversal mid-ramp
        en_a = 1'b1;
        edges(4); chk("rev_e3_level", 512'(level_a), 512'(2));
        en_a = 1'b0;
        edges(1); chk("rev_e4_level", 512'(level_a), 512'(1));
        edges(2); chk("rev_e6_level", 512'(level_a), 512'(1));
        edges(1); chk("rev_e7_level", 512'(level_a), 512'(0));
        edges(2);

        // force_off pulse during ramp-up, restart with enable still high
        en_a = 1'b1;
        edges(5);
        f_a = 1'b1;
        edges(1);
        chk("frc_e5_hi",    512'(hi_a),    512'(0));
        chk("frc_e5_level", 512'(level_a), 512'(0));
        f_a = 1'b0;
        edges(1); chk("frc_e6_hi", 512'(hi_a), 512'(10'h007));
        edges(4);
        f_a = 1'b1;
        edges(3); chk("frc_hold_level", 512'(level_a), 512'(0));
        f_a = 1'b0; en_a = 1'b0;
        edges(2);

        // Corner instance: single group, one-cycle stage
        en_b = 1'b1;
        edges(1);
        chk("b_on_hi",    512'(hi_b),    512'(ones));
        chk("b_on_ready", 512'(ready_b), 512'(1));
        for (int k = 0; k < 6; k++) begin
            en_b = ~en_b;
            edges(1);
            chk("b_toggle", 512'(hi_b), en_b ? 512'(ones) : 512'(0));
        end
        f_b = 1'b1;
        edges(1); chk("b_force", 512'(hi_b), 512'(0));
        f_b = 1'b0; en_b = 1'b1;
        edges(1); chk("b_restart", 512'(hi_b), 512'(ones));

        // Reset mid-ramp
        en_a = 1'b1;
        edges(4); chk("rmr_e3_level", 512'(level_a), 512'(2));
        rst = 1'b1;
        edges(1);
        chk("rmr_hi",    512'(hi_a),    512'(0));
        chk("rmr_level", 512'(level_a), 512'(0));
        chk("rmr_busy",  512'(busy_a),  512'(0));
        chk("rmr_hi_b",  512'(hi_b),    512'(0));
        edges(4);
        chk("rmr_held_level", 512'(level_a), 512'(0));
        rst = 1'b0; en_a = 1'b0; en_b = 1'b0;
        edges(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
